// File: rtl/rpn_stack_core.sv
// rpn_stack_core: small signed 8-bit RPN calculator stack.
// Entry 0 of the stack array is the top of stack; pushes shift entries down.
// Optional feature: define RPN_MUL_EN to build the 8-cycle shift-add multiplier
// (op_code 10). Without it, op_code 10 reports an illegal op.
module rpn_stack_core #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       push,
  input  logic       pop,
  input  logic       op,
  input  logic [1:0] op_code,
  output logic [7:0] top,
  output logic       top_valid,
  output logic [2:0] depth,
  output logic       busy,
  output logic [1:0] err
);

  localparam logic [2:0] DEPTH_L  = 3'(DEPTH);
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_MUL   = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;
  localparam logic [1:0] ERR_ILL  = 2'b11;

  logic [7:0] stack_reg  [DEPTH];
  logic [7:0] stack_next [DEPTH];
  logic [7:0] push_shift [DEPTH];
  logic [7:0] pop_shift  [DEPTH];
  logic [2:0] depth_reg, depth_next;
  logic [1:0] err_reg, err_next;
  logic [7:0] top_reg, top_next;
  logic       top_valid_reg;

`ifdef RPN_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;
  state_t     state_reg, state_next;
  logic [7:0] mul_a_reg, mul_a_next;
  logic [7:0] mul_b_reg, mul_b_next;
  logic [7:0] mul_acc_reg, mul_acc_next;
  logic [2:0] mul_cnt_reg, mul_cnt_next;
  logic [7:0] mul_acc_step;
`endif

  // Precomputed shifted views of the stack for push (down) and pop/binary op (up).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
      if (gi == 0) begin : g_first
        assign push_shift[gi] = din;
      end else begin : g_rest
        assign push_shift[gi] = stack_reg[gi-1];
      end
      if (gi == DEPTH - 1) begin : g_last
        assign pop_shift[gi] = 8'd0;
      end else begin : g_inner
        assign pop_shift[gi] = stack_reg[gi+1];
      end
    end
  endgenerate

`ifdef RPN_MUL_EN
  // One shift-add step: add a<<k when bit k of b is set (8-bit wrap).
  assign mul_acc_step = mul_acc_reg + (mul_b_reg[mul_cnt_reg] ? (mul_a_reg << mul_cnt_reg) : 8'd0);
`endif

  // Next-state logic: mul progress first, then arbitrated pulses push > pop > op.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) stack_next[i] = stack_reg[i];
    depth_next = depth_reg;
    err_next   = err_reg;
`ifdef RPN_MUL_EN
    state_next   = state_reg;
    mul_a_next   = mul_a_reg;
    mul_b_next   = mul_b_reg;
    mul_acc_next = mul_acc_reg;
    mul_cnt_next = mul_cnt_reg;
    if (state_reg == ST_MUL) begin
      // Pulses are ignored here; only the multiplier advances.
      mul_acc_next = mul_acc_step;
      mul_cnt_next = mul_cnt_reg + 3'd1;
      if (mul_cnt_reg == 3'd7) begin
        for (int i = 0; i < DEPTH; i++) stack_next[i] = pop_shift[i];
        stack_next[0] = mul_acc_step;
        depth_next    = depth_reg - 3'd1;
        err_next      = ERR_NONE;
        state_next    = ST_IDLE;
      end
    end else
`endif
    if (push) begin
      if (depth_reg < DEPTH_L) begin
        for (int i = 0; i < DEPTH; i++) stack_next[i] = push_shift[i];
        depth_next = depth_reg + 3'd1;
        err_next   = ERR_NONE;
      end else begin
        err_next = ERR_OVF;
      end
    end else if (pop) begin
      if (depth_reg != 3'd0) begin
        for (int i = 0; i < DEPTH; i++) stack_next[i] = pop_shift[i];
        depth_next = depth_reg - 3'd1;
        err_next   = ERR_NONE;
      end else begin
        err_next = ERR_UNF;
      end
    end else if (op) begin
      if (depth_reg < 3'd2) begin
        err_next = ERR_UNF;
      end else begin
        case (op_code)
          OP_ADD: begin
            for (int i = 0; i < DEPTH; i++) stack_next[i] = pop_shift[i];
            stack_next[0] = stack_reg[1] + stack_reg[0];
            depth_next    = depth_reg - 3'd1;
            err_next      = ERR_NONE;
          end
          OP_SUB: begin
            for (int i = 0; i < DEPTH; i++) stack_next[i] = pop_shift[i];
            stack_next[0] = stack_reg[1] - stack_reg[0];
            depth_next    = depth_reg - 3'd1;
            err_next      = ERR_NONE;
          end
          OP_SWAP: begin
            stack_next[0] = stack_reg[1];
            stack_next[1] = stack_reg[0];
            err_next      = ERR_NONE;
          end
          OP_MUL: begin
`ifdef RPN_MUL_EN
            // Operands are latched; stack and depth stay put until the result lands.
            state_next   = ST_MUL;
            mul_a_next   = stack_reg[1];
            mul_b_next   = stack_reg[0];
            mul_acc_next = 8'd0;
            mul_cnt_next = 3'd0;
`else
            err_next = ERR_ILL;
`endif
          end
          default: err_next = ERR_ILL;
        endcase
      end
    end
    // Visible top is forced to zero on an empty stack, whatever the entry holds.
    top_next = (depth_next == 3'd0) ? 8'd0 : stack_next[0];
  end

  // Stack, depth, error and registered output state.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= 8'd0;
      depth_reg     <= 3'd0;
      err_reg       <= ERR_NONE;
      top_reg       <= 8'd0;
      top_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stack_reg[i] <= stack_next[i];
      depth_reg     <= depth_next;
      err_reg       <= err_next;
      top_reg       <= top_next;
      top_valid_reg <= (depth_next != 3'd0);
    end
  end

`ifdef RPN_MUL_EN
  // FSM state register plus multiplier datapath; reset aborts a running mul.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      mul_a_reg   <= 8'd0;
      mul_b_reg   <= 8'd0;
      mul_acc_reg <= 8'd0;
      mul_cnt_reg <= 3'd0;
    end else begin
      state_reg   <= state_next;
      mul_a_reg   <= mul_a_next;
      mul_b_reg   <= mul_b_next;
      mul_acc_reg <= mul_acc_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

  assign busy = (state_reg == ST_MUL);
`else
  assign busy = 1'b0;
`endif

  assign top       = top_reg;
  assign top_valid = top_valid_reg;
  assign depth     = depth_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_rpn_stack_core.sv
// Self-checking bench for rpn_stack_core (DEPTH=4). Honours RPN_MUL_EN.
module tb_rpn_stack_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] din = 8'd0;
  logic       push = 1'b0, pop = 1'b0, op = 1'b0;
  logic [1:0] op_code = 2'b00;
  logic [7:0] top;
  logic       top_valid;
  logic [2:0] depth;
  logic       busy;
  logic [1:0] err;

  int checks = 0;
  int failures = 0;

  rpn_stack_core #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .din(din), .push(push), .pop(pop), .op(op),
    .op_code(op_code), .top(top), .top_valid(top_valid), .depth(depth),
    .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, pu, po, o;
    logic [1:0] oc;
    logic [7:0] d;
    logic [7:0] e_top;
    logic [2:0] e_depth;
    logic [1:0] e_err;
    logic       e_busy;
    string      name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input string nm, input logic r, input logic pu, input logic po,
                              input logic o, input logic [1:0] oc, input logic [7:0] d,
                              input logic [7:0] t, input int dp, input logic [1:0] e,
                              input logic b);
    vec_t v;
    v.name = nm; v.rst = r; v.pu = pu; v.po = po; v.o = o; v.oc = oc; v.d = d;
    v.e_top = t; v.e_depth = 3'(dp); v.e_err = e; v.e_busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample #1 after the edge.
  task automatic run(input vec_t v);
    vec_t e;
    @(negedge clock);
    reset = v.rst; push = v.pu; pop = v.po; op = v.o; op_code = v.oc; din = v.d;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; op = 1'b0;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: scoreboard empty", v.name);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, ".top"}, int'(top), int'(e.e_top));
      chk({e.name, ".depth"}, int'(depth), int'(e.e_depth));
      chk({e.name, ".err"}, int'(err), int'(e.e_err));
      chk({e.name, ".busy"}, int'(busy), int'(e.e_busy));
      chk({e.name, ".top_valid"}, int'(top_valid), (e.e_depth != 3'd0) ? 1 : 0);
      $display("txn %-14s top=%0d depth=%0d err=%0d busy=%0d", e.name,
               $signed(top), depth, err, busy);
    end
  endtask

  initial begin
    //               name        rst pu po o  oc     din      top        dp err    busy
    vecs.push_back(mk("reset",    1, 0, 0, 0, 2'b00, 8'd0,   8'd0,      0, 2'b00, 0));
    vecs.push_back(mk("push5",    0, 1, 0, 0, 2'b00, 8'd5,   8'd5,      1, 2'b00, 0));
    vecs.push_back(mk("push3",    0, 1, 0, 0, 2'b00, 8'd3,   8'd3,      2, 2'b00, 0));
    vecs.push_back(mk("add",      0, 0, 0, 1, 2'b00, 8'd0,   8'd8,      1, 2'b00, 0));
    vecs.push_back(mk("pop",      0, 0, 1, 0, 2'b00, 8'd0,   8'd0,      0, 2'b00, 0));
    vecs.push_back(mk("push100a", 0, 1, 0, 0, 2'b00, 8'd100, 8'd100,    1, 2'b00, 0));
    vecs.push_back(mk("push100b", 0, 1, 0, 0, 2'b00, 8'd100, 8'd100,    2, 2'b00, 0));
    vecs.push_back(mk("add_wrap", 0, 0, 0, 1, 2'b00, 8'd0,   8'hC8,     1, 2'b00, 0));
    vecs.push_back(mk("push3b",   0, 1, 0, 0, 2'b00, 8'd3,   8'd3,      2, 2'b00, 0));
    vecs.push_back(mk("push7",    0, 1, 0, 0, 2'b00, 8'd7,   8'd7,      3, 2'b00, 0));
    vecs.push_back(mk("sub",      0, 0, 0, 1, 2'b01, 8'd0,   8'(-4),    2, 2'b00, 0));
    vecs.push_back(mk("swap1",    0, 0, 0, 1, 2'b11, 8'd0,   8'hC8,     2, 2'b00, 0));
    vecs.push_back(mk("swap2",    0, 0, 0, 1, 2'b11, 8'd0,   8'(-4),    2, 2'b00, 0));
    vecs.push_back(mk("pop_a",    0, 0, 1, 0, 2'b00, 8'd0,   8'hC8,     1, 2'b00, 0));
    vecs.push_back(mk("pop_b",    0, 0, 1, 0, 2'b00, 8'd0,   8'd0,      0, 2'b00, 0));
    vecs.push_back(mk("pop_unf",  0, 0, 1, 0, 2'b00, 8'd0,   8'd0,      0, 2'b10, 0));
    vecs.push_back(mk("push1",    0, 1, 0, 0, 2'b00, 8'd1,   8'd1,      1, 2'b00, 0));
    vecs.push_back(mk("op_unf",   0, 0, 0, 1, 2'b00, 8'd0,   8'd1,      1, 2'b10, 0));
    vecs.push_back(mk("push2",    0, 1, 0, 0, 2'b00, 8'd2,   8'd2,      2, 2'b00, 0));
    vecs.push_back(mk("push3c",   0, 1, 0, 0, 2'b00, 8'd3,   8'd3,      3, 2'b00, 0));
    vecs.push_back(mk("push4",    0, 1, 0, 0, 2'b00, 8'd4,   8'd4,      4, 2'b00, 0));
    vecs.push_back(mk("push_ovf", 0, 1, 0, 0, 2'b00, 8'd5,   8'd4,      4, 2'b01, 0));
    vecs.push_back(mk("pop_clr",  0, 0, 1, 0, 2'b00, 8'd0,   8'd3,      3, 2'b00, 0));
    vecs.push_back(mk("push+pop", 0, 1, 1, 0, 2'b00, 8'd9,   8'd9,      4, 2'b00, 0));
    vecs.push_back(mk("pop+op",   0, 0, 1, 1, 2'b00, 8'd0,   8'd3,      3, 2'b00, 0));
    vecs.push_back(mk("pop_c",    0, 0, 1, 0, 2'b00, 8'd0,   8'd2,      2, 2'b00, 0));
    vecs.push_back(mk("pop_d",    0, 0, 1, 0, 2'b00, 8'd0,   8'd1,      1, 2'b00, 0));
    vecs.push_back(mk("pushpop1", 0, 1, 1, 0, 2'b00, 8'd6,   8'd6,      2, 2'b00, 0));
    vecs.push_back(mk("sub_neg",  0, 0, 0, 1, 2'b01, 8'd0,   8'(-5),    1, 2'b00, 0));
    vecs.push_back(mk("pop_e",    0, 0, 1, 0, 2'b00, 8'd0,   8'd0,      0, 2'b00, 0));
    vecs.push_back(mk("push127",  0, 1, 0, 0, 2'b00, 8'd127, 8'd127,    1, 2'b00, 0));
    vecs.push_back(mk("push1b",   0, 1, 0, 0, 2'b00, 8'd1,   8'd1,      2, 2'b00, 0));
    vecs.push_back(mk("add_ovf",  0, 0, 0, 1, 2'b00, 8'd0,   8'h80,     1, 2'b00, 0));
    vecs.push_back(mk("pop_f",    0, 0, 1, 0, 2'b00, 8'd0,   8'd0,      0, 2'b00, 0));

    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

    // Multiply corner: -3 * 5 with a push pulse arriving mid-operation.
    run(mk("push_m3",  0, 1, 0, 0, 2'b00, 8'(-3), 8'(-3), 1, 2'b00, 0));
    run(mk("push5m",   0, 1, 0, 0, 2'b00, 8'd5,   8'd5,   2, 2'b00, 0));
`ifdef RPN_MUL_EN
    run(mk("mul_go",   0, 0, 0, 1, 2'b10, 8'd0,   8'd5,   2, 2'b00, 1));
    for (int k = 1; k < 8; k++)
      run(mk("mul_busy", 0, (k == 3), 0, 0, 2'b00, 8'd99, 8'd5, 2, 2'b00, 1));
    run(mk("mul_done", 0, 0, 0, 0, 2'b00, 8'd0,   8'(-15), 1, 2'b00, 0));
    run(mk("pop_m",    0, 0, 1, 0, 2'b00, 8'd0,   8'd0,   0, 2'b00, 0));
    // Reset in the middle of a multiply aborts it.
    run(mk("push2r",   0, 1, 0, 0, 2'b00, 8'd2,   8'd2,   1, 2'b00, 0));
    run(mk("push2s",   0, 1, 0, 0, 2'b00, 8'd2,   8'd2,   2, 2'b00, 0));
    run(mk("mul_go2",  0, 0, 0, 1, 2'b10, 8'd0,   8'd2,   2, 2'b00, 1));
    run(mk("mul_busy2",0, 0, 0, 0, 2'b00, 8'd0,   8'd2,   2, 2'b00, 1));
    run(mk("rst_mul",  1, 0, 0, 0, 2'b00, 8'd0,   8'd0,   0, 2'b00, 0));
    run(mk("after_rst",0, 0, 0, 0, 2'b00, 8'd0,   8'd0,   0, 2'b00, 0));
`else
    run(mk("mul_ill",  0, 0, 0, 1, 2'b10, 8'd0,   8'd5,   2, 2'b11, 0));
    run(mk("ill_hold", 0, 0, 0, 0, 2'b00, 8'd0,   8'd5,   2, 2'b11, 0));
    run(mk("pop_i1",   0, 0, 1, 0, 2'b00, 8'd0,   8'(-3), 1, 2'b00, 0));
    run(mk("pop_i2",   0, 0, 1, 0, 2'b00, 8'd0,   8'd0,   0, 2'b00, 0));
    run(mk("push2r",   0, 1, 0, 0, 2'b00, 8'd2,   8'd2,   1, 2'b00, 0));
    run(mk("push2s",   0, 1, 0, 0, 2'b00, 8'd2,   8'd2,   2, 2'b00, 0));
    run(mk("mul_ill2", 0, 0, 0, 1, 2'b10, 8'd0,   8'd2,   2, 2'b11, 0));
    run(mk("rst_mul",  1, 1, 0, 0, 2'b00, 8'd7,   8'd0,   0, 2'b00, 0));
    run(mk("after_rst",0, 0, 0, 0, 2'b00, 8'd0,   8'd0,   0, 2'b00, 0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
